// File: rtl/order_book_pkg.sv
// Shared types and constants for the order book front end.
package order_book_pkg;

  localparam int unsigned ID_W    = 32;
  localparam int unsigned QTY_W   = 32;
  localparam int unsigned PRICE_W = 64;
  localparam int unsigned TYPE_W  = 3;

  localparam logic [TYPE_W-1:0] REQ_ADD      = 3'b100;
  localparam logic [TYPE_W-1:0] REQ_DELETE   = 3'b010;
  localparam logic [TYPE_W-1:0] REQ_DECREASE = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_LOW  = 2'd2,
    ST_WAIT_HIGH = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [ID_W-1:0]    order_id;
    logic [QTY_W-1:0]   quantity;
    logic [PRICE_W-1:0] price;
  } order_req_t;

  // Only the three one-hot codes are legal.
  function automatic logic is_legal_type(input logic [TYPE_W-1:0] t);
    return (t == REQ_ADD) || (t == REQ_DELETE) || (t == REQ_DECREASE);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             any_o
);

  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] p, input int unsigned k);
    int unsigned s;
    s = 32'(p) + k;
    if (s >= N) s = s - N;
    return PTR_W'(s);
  endfunction

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!any_o && req_i[wrap_idx(ptr_i, k)]) begin
        any_o                      = 1'b1;
        idx_o                      = wrap_idx(ptr_i, k);
        grant_o[wrap_idx(ptr_i, k)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/order_req_arbiter.sv
// Round-robin arbiter staging one request at a time into the order book engine.
// Optional: ORDER_ARB_DELETE_PRIORITY_EN lets valid delete requests win arbitration.
module order_req_arbiter
  import order_book_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [TYPE_W*NUM_REQ-1:0]     req_type,
  input  logic [ID_W*NUM_REQ-1:0]       req_order_id,
  input  logic [QTY_W*NUM_REQ-1:0]      req_quantity,
  input  logic [PRICE_W*NUM_REQ-1:0]    req_price,
  output logic                          book_valid,
  output logic [TYPE_W-1:0]             book_req_type,
  output logic [ID_W-1:0]               book_order_id,
  output logic [QTY_W-1:0]              book_quantity,
  output logic [PRICE_W-1:0]            book_price,
  input  logic                          book_ready,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          err_bad_type,
  output logic                          err_timeout,
  output logic [31:0]                   issued_count
);

  localparam int unsigned GNT_W   = $clog2(NUM_REQ);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  arb_state_e          state_q, state_d;
  logic [GNT_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [GNT_W-1:0]    grant_q, grant_d;
  logic [TYPE_W-1:0]   type_q, type_d;
  order_req_t          stage_q, stage_d;
  logic                book_valid_q, book_valid_d;
  logic                err_bt_q, err_bt_d;
  logic                err_to_q, err_to_d;
  logic [31:0]         issued_q, issued_d;
  logic                wl_cnt_q, wl_cnt_d;
  logic [31:0]         wh_cnt_q, wh_cnt_d;

  logic [NUM_REQ-1:0]  pick_req, pick_gnt;
  logic [GNT_W-1:0]    pick_idx;
  logic                pick_any;
  logic [TYPE_W-1:0]   sel_type;
  order_req_t          sel_req;

`ifdef ORDER_ARB_DELETE_PRIORITY_EN
  logic [NUM_REQ-1:0]  is_del;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      is_del[i] = (req_type[TYPE_W*i +: TYPE_W] == REQ_DELETE);
    end
  end

  // Deletes mask out every other requester whenever at least one is valid.
  assign pick_req = (|(req_valid & is_del)) ? (req_valid & is_del) : req_valid;
`else
  assign pick_req = req_valid;
`endif

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (GNT_W)
  ) u_rr_pick (
    .req_i   (pick_req),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Payload of the currently picked requester.
  always_comb begin
    sel_type = '0;
    sel_req  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) begin
        sel_type         = req_type[TYPE_W*i +: TYPE_W];
        sel_req.order_id = req_order_id[ID_W*i +: ID_W];
        sel_req.quantity = req_quantity[QTY_W*i +: QTY_W];
        sel_req.price    = req_price[PRICE_W*i +: PRICE_W];
      end
    end
  end

  // Ready is held low while reset is asserted so nothing is consumed then.
  assign req_ready = ((state_q == ST_IDLE) && reset) ? pick_gnt : '0;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    type_d       = type_q;
    stage_d      = stage_q;
    book_valid_d = book_valid_q;
    err_bt_d     = 1'b0;
    err_to_d     = 1'b0;
    issued_d     = issued_q;
    wl_cnt_d     = wl_cnt_q;
    wh_cnt_d     = wh_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          type_d   = sel_type;
          stage_d  = sel_req;
          grant_d  = pick_idx;
          rr_ptr_d = (32'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + GNT_W'(1);
          if (is_legal_type(sel_type)) begin
            state_d      = ST_ISSUE;
            book_valid_d = 1'b1;
          end else begin
            err_bt_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (book_ready) begin
          book_valid_d = 1'b0;
          issued_d     = issued_q + 32'd1;
          wl_cnt_d     = 1'b0;
          state_d      = ST_WAIT_LOW;
        end
      end
      // A high ready right after acceptance is stale; give it two cycles to drop.
      ST_WAIT_LOW: begin
        if (!book_ready) begin
          state_d  = ST_WAIT_HIGH;
          wh_cnt_d = '0;
        end else if (wl_cnt_q) begin
          state_d = ST_IDLE;
        end else begin
          wl_cnt_d = 1'b1;
        end
      end
      ST_WAIT_HIGH: begin
        if (book_ready) begin
          state_d = ST_IDLE;
        end else if (wh_cnt_q == TO_LAST) begin
          err_to_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          wh_cnt_d = wh_cnt_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      type_q       <= '0;
      stage_q      <= '0;
      book_valid_q <= 1'b0;
      err_bt_q     <= 1'b0;
      err_to_q     <= 1'b0;
      issued_q     <= '0;
      wl_cnt_q     <= 1'b0;
      wh_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      type_q       <= type_d;
      stage_q      <= stage_d;
      book_valid_q <= book_valid_d;
      err_bt_q     <= err_bt_d;
      err_to_q     <= err_to_d;
      issued_q     <= issued_d;
      wl_cnt_q     <= wl_cnt_d;
      wh_cnt_q     <= wh_cnt_d;
    end
  end

  assign book_valid    = book_valid_q;
  assign book_req_type = type_q;
  assign book_order_id = stage_q.order_id;
  assign book_quantity = stage_q.quantity;
  assign book_price    = stage_q.price;
  assign busy          = (state_q != ST_IDLE);
  assign grant_id      = grant_q;
  assign err_bad_type  = err_bt_q;
  assign err_timeout   = err_to_q;
  assign issued_count  = issued_q;

endmodule
